// File: rtl/wallace_csa_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined
// carry-save reduction tree.
//   WIDTH_DATA     : base data width; the tree defaults to twice this.
//   csa_next(n)    : operand count after one 3:2 level applied to n operands.
//   csa_ops(n, l)  : operand count entering level l of a tree fed n operands.
//   csa_levels(n)  : number of levels needed to reduce n operands to 2.
package wallace_csa_pipe_pkg;

  localparam int WIDTH_DATA = 16;

  function automatic int csa_next(input int n);
    return n - n / 3;
  endfunction

  function automatic int csa_ops(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = csa_next(c);
    return c;
  endfunction

  // Bounded loop: 16 operands need only 6 levels, so 16 iterations is ample.
  function automatic int csa_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    for (int i = 0; i < 16; i++) begin
      if (c > 2) begin
        c = csa_next(c);
        l++;
      end
    end
    return l;
  endfunction

endpackage

// File: rtl/wallace_csa_pipe_level.sv
// One combinational level of the 3:2 carry-save tree.
//   in  : NIN operands of W bits, operand k at in[k*W +: W].
//   out : NIN - floor(NIN/3) operands. Per CSA the sum then the carry
//         (carry already shifted left by one, MSB dropped), followed by the
//         NIN mod 3 passthrough operands in their original order.
module csa_level #(
  parameter int W   = 32,
  parameter int NIN = 3
) (
  input  logic [NIN*W-1:0]             in,
  output logic [(NIN - NIN/3)*W-1:0]   out
);

  localparam int NC = NIN / 3;
  localparam int NP = NIN % 3;

  for (genvar k = 0; k < NC; k++) begin : g_csa
    logic [W-1:0] a, b, c, maj;
    assign a   = in[(3*k)*W   +: W];
    assign b   = in[(3*k+1)*W +: W];
    assign c   = in[(3*k+2)*W +: W];
    assign maj = (a & b) | (a & c) | (b & c);
    assign out[(2*k)*W   +: W] = a ^ b ^ c;
    // Shifting within W bits discards the carry out of the MSB (mod 2^W).
    assign out[(2*k+1)*W +: W] = maj << 1;
  end

  for (genvar p = 0; p < NP; p++) begin : g_pass
    assign out[(2*NC+p)*W +: W] = in[(3*NC+p)*W +: W];
  end

endmodule

// File: rtl/wallace_csa_pipe.sv
// Pipelined carry-save reduction of N partial products (mod 2^W) with a
// valid/ready stream interface. L CSA stages plus one carry-propagate stage.
//   clk, rst_n          : clock, async active-low reset.
//   clr                 : synchronous flush of all pipeline valid bits.
//   in_valid/in_ready   : input handshake; pp holds N operands of W bits.
//   out_valid/out_ready : output handshake.
//   out_sum/out_carry   : redundant pair (carry weight-aligned).
//   out_result          : out_sum + out_carry mod 2^W.
module wallace_csa_pipe
  import wallace_csa_pipe_pkg::*;
#(
  parameter int W = WIDTH_DATA * 2,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] pp,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_sum,
  output logic [W-1:0]   out_carry,
  output logic [W-1:0]   out_result
);

  localparam int L = csa_levels(N);

  // vld[j] for j < L belongs to CSA stage j; vld[L] is the output stage.
  logic [L:0] vld;
  logic       en;

  // Global stall: the whole pipe freezes when the output is held, so
  // in_ready never depends on in_valid.
  assign en        = ~vld[L] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld[L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld <= '0;
    else if (clr) vld <= '0;
    else if (en)  vld <= {vld[L-1:0], in_valid};
  end

  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int NI = csa_ops(N, j);
    localparam int NO = csa_ops(N, j + 1);

    logic [NI*W-1:0] d_in;
    logic [NO*W-1:0] d_nxt;
    logic [NO*W-1:0] d_q;
    logic            ld;

    if (j == 0) begin : g_first
      assign d_in = pp;
      assign ld   = en & in_valid;
    end else begin : g_rest
      assign d_in = g_lvl[j-1].d_q;
      assign ld   = en & vld[j-1];
    end

    csa_level #(.W(W), .NIN(NI)) u_csa (
      .in  (d_in),
      .out (d_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  d_q <= '0;
      else if (ld) d_q <= d_nxt;
    end
  end

  // The last level always reduces 3 operands, so its output is (sum, carry).
  logic [W-1:0] fin_s, fin_c;
  assign fin_s = g_lvl[L-1].d_q[W-1:0];
  assign fin_c = g_lvl[L-1].d_q[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum    <= '0;
      out_carry  <= '0;
      out_result <= '0;
    end else if (en & vld[L-1]) begin
      out_sum    <= fin_s;
      out_carry  <= fin_c;
      out_result <= fin_s + fin_c;
    end
  end

endmodule

// File: tb/tb_wallace_csa_pipe.sv
// Scoreboard bench for wallace_csa_pipe: N=8/W=32 main instance plus
// N=3 and N=16 (W=16) instances for the parameter sweep.
module tb_wallace_csa_pipe;

  localparam int W   = 32;
  localparam int N   = 8;
  localparam int L   = 4;
  localparam int L3  = 1;
  localparam int L16 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, clr, in_valid, in_ready, out_valid, out_ready;
  logic [N*W-1:0] pp;
  logic [W-1:0]   out_sum, out_carry, out_result;

  logic           iv3, ir3, ov3;
  logic [47:0]    pp3;
  logic [15:0]    os3, oc3, or3;
  logic           iv16, ir16, ov16;
  logic [255:0]   pp16;
  logic [15:0]    os16, oc16, or16;

  wallace_csa_pipe #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .pp(pp), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_result(out_result));

  wallace_csa_pipe #(.W(16), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .in_valid(iv3), .in_ready(ir3),
    .pp(pp3), .out_valid(ov3), .out_ready(1'b1), .out_sum(os3),
    .out_carry(oc3), .out_result(or3));

  wallace_csa_pipe #(.W(16), .N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .in_valid(iv16), .in_ready(ir16),
    .pp(pp16), .out_valid(ov16), .out_ready(1'b1), .out_sum(os16),
    .out_carry(oc16), .out_result(or16));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [15:0] e3_q[$], e16_q[$];
  int          l3_q[$], l16_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: plain modular sum of the operand slices.
  function automatic logic [31:0] ref8(input logic [255:0] v);
    logic [31:0] s = '0;
    for (int k = 0; k < 8; k++) s += v[k*32 +: 32];
    return s;
  endfunction

  function automatic logic [15:0] ref16(input logic [255:0] v, input int n);
    logic [15:0] s = '0;
    for (int k = 0; k < n; k++) s += v[k*16 +: 16];
    return s;
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom % 2);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Main monitor: pops on every transfer, checks hold-stability and in_ready during stalls.
  logic        stall_p = 1'b0;
  logic [31:0] ps, pc, pr, mon_e;
  int          mon_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p <= 1'b0;
    end else begin
      if (stall_p) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", out_result, pr);
        chk("hold_sum", out_sum, ps);
        chk("hold_carry", out_carry, pc);
      end
      if (out_valid && !out_ready) chk("in_ready_stall", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h required=no_output", out_result);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          chk("result", out_result, mon_e);
          chk("sum_plus_carry", out_sum + out_carry, mon_e);
          if (mon_l >= 0) chk("latency", cyc, mon_l);
        end
      end
      stall_p <= out_valid & ~out_ready;
      ps <= out_sum;
      pc <= out_carry;
      pr <= out_result;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov3) begin
      if (e3_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL n3_unexpected actual=%h required=no_output", or3);
      end else begin
        chk("n3_result", 32'(or3), 32'(e3_q[0]));
        chk("n3_sum_plus_carry", 32'(16'(os3 + oc3)), 32'(e3_q.pop_front()));
        chk("n3_latency", cyc, l3_q.pop_front());
      end
    end
    if (rst_n && ov16) begin
      if (e16_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL n16_unexpected actual=%h required=no_output", or16);
      end else begin
        chk("n16_result", 32'(or16), 32'(e16_q[0]));
        chk("n16_sum_plus_carry", 32'(16'(os16 + oc16)), 32'(e16_q.pop_front()));
        chk("n16_latency", cyc, l16_q.pop_front());
      end
    end
  end

  // Present one beat; the accept edge is the posedge after a negedge with in_ready=1.
  task automatic send(input logic [255:0] v, input logic [31:0] e, input bit push, input bit lat);
    int n = 0;
    pp = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end else if (push) begin
      exp_q.push_back(e);
      lat_q.push_back(lat ? cyc + L + 1 : -1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() + e3_q.size() + e16_q.size()) != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size() + e3_q.size() + e16_q.size()), 32'd0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  logic [255:0] v, r3, r16;

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; pp = '0;
    iv3 = 1'b0; iv16 = 1'b0; pp3 = '0; pp16 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_carry", out_carry, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    send({8{32'h0000_0001}}, 32'd8, 1'b1, 1'b1);
    drain();
    send({8{32'hFFFF_FFFF}}, 32'hFFFF_FFF8, 1'b1, 1'b1);
    drain();

    // Back-to-back with no stalls: full throughput and fixed latency.
    for (int i = 0; i < 8; i++) begin
      v = rnd();
      send(v, ref8(v), 1'b1, 1'b1);
    end
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      v = rnd();
      send(v, ref8(v), 1'b1, 1'b0);
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Flush: three beats lost, next beat emerges with normal latency.
    for (int i = 0; i < 3; i++) send(rnd(), 32'd0, 1'b0, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    v = rnd();
    send(v, ref8(v), 1'b1, 1'b1);
    drain();

    // Reset mid-stream with a stalled beat held at the output.
    rdy_mode = 2;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) send(rnd(), 32'd0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    chk("stall_full_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    chk("midrst_out_sum", out_sum, 32'd0);
    chk("midrst_out_carry", out_carry, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    rdy_mode = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    v = rnd();
    send(v, ref8(v), 1'b1, 1'b1);
    drain();

    // Parameter sweep: N=3 and N=16 at W=16, one beat per cycle.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      r3 = rnd();
      r3[255:48] = '0;
      r16 = rnd();
      pp3 = r3[47:0];
      pp16 = r16;
      iv3 = 1'b1;
      iv16 = 1'b1;
      chk("n3_in_ready", 32'(ir3), 32'd1);
      chk("n16_in_ready", 32'(ir16), 32'd1);
      e3_q.push_back(ref16(r3, 3));
      l3_q.push_back(cyc + L3 + 1);
      e16_q.push_back(ref16(r16, 16));
      l16_q.push_back(cyc + L16 + 1);
    end
    @(posedge clk);
    #1;
    iv3 = 1'b0;
    iv16 = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
